// File: rtl/ladybird_trap_unit_pkg.sv
// Shared ladybird configuration: CSR map, mstatus bit positions, cause codes
// and the mtvec mode encoding used by the trap unit.
package ladybird_config;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam int MSTATUS_MIE_BIT  = 3;
    localparam int MSTATUS_MPIE_BIT = 7;

    localparam int CAUSE_ECALL_M    = 11;
    localparam int CAUSE_BREAKPOINT = 3;

    typedef enum logic [1:0] {
        TVEC_DIRECT   = 2'd0,
        TVEC_VECTORED = 2'd1
    } tvec_mode_e;

    // Reserved mtvec modes (2/3) collapse to direct.
    function automatic logic [1:0] tvec_legal(input logic [1:0] mode);
        return (mode == TVEC_VECTORED) ? TVEC_VECTORED : TVEC_DIRECT;
    endfunction

endpackage

// File: rtl/ladybird_prio_enc.sv
// Lowest-index-first priority encoder for the interrupt request vector.
module ladybird_prio_enc #(
    parameter int NUM_IRQ = 8,
    parameter int IDX_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic               valid,
    output logic [IDX_W-1:0]   index
);

    // Scan high to low so the lowest set bit is the last one written.
    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/ladybird_trap_unit.sv
// Machine-mode trap/interrupt controller: mstatus/mie/mtvec/mepc/mcause/mip,
// prioritised level/edge interrupts, and the commit-stage PC redirect for
// ECALL, EBREAK, MRET and interrupts.
module ladybird_trap_unit
    import ladybird_config::*;
#(
    parameter int               XLEN       = 32,
    parameter int               NUM_IRQ    = 8,
    parameter logic [NUM_IRQ-1:0] IRQ_EDGE = '0,
    parameter logic [XLEN-1:0]  TVEC_RESET = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               commit_valid,
    input  logic [XLEN-1:0]    commit_pc,
    input  logic [XLEN-1:0]    commit_pc_n,
    input  logic               is_ecall,
    input  logic               is_ebreak,
    input  logic               is_mret,
    input  logic               csr_we,
    input  logic [11:0]        csr_addr,
    input  logic [XLEN-1:0]    csr_wdata,
    output logic [XLEN-1:0]    csr_rdata,
    output logic               redirect_valid,
    output logic [XLEN-1:0]    redirect_pc,
    output logic               complete
);

    localparam int              IDX_W      = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] mie_q;
    logic               mstatus_mie;
    logic               mstatus_mpie;
    logic [XLEN-1:0]    mtvec_q;
    logic [XLEN-1:0]    mepc_q;
    logic [XLEN-1:0]    mcause_q;

    logic               win_valid;
    logic [IDX_W-1:0]   win_idx;
    logic               exc;
    logic               take_irq;
    logic               do_mret;
    logic               trap;
    logic               wr_mip;
    logic [XLEN-1:0]    tvec_base;
    logic [XLEN-1:0]    vec_off;

    assign wr_mip    = csr_we && (csr_addr == CSR_MIP);
    assign tvec_base = {mtvec_q[XLEN-1:2], 2'b00};
    assign vec_off   = XLEN'(win_idx) << 2;

    // Per-source pending: level sources mirror irq_q, edge sources latch.
    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_lane
        if (IRQ_EDGE[i]) begin : g_edge
            logic ep;
            logic rise;
            logic clr;
            assign rise = irq[i] && !irq_q[i];
            assign clr  = (take_irq && (win_idx == IDX_W'(i))) ||
                          (wr_mip && !csr_wdata[i]);
            // Rising edge sets, take or mip write of 0 clears; set wins.
            always_ff @(posedge clk) begin
                if (rst)       ep <= 1'b0;
                else if (rise) ep <= 1'b1;
                else if (clr)  ep <= 1'b0;
            end
            assign pending[i] = ep;
        end else begin : g_level
            assign pending[i] = irq_q[i];
        end
    end

    ladybird_prio_enc #(
        .NUM_IRQ (NUM_IRQ),
        .IDX_W   (IDX_W)
    ) u_prio (
        .req   (pending & mie_q),
        .valid (win_valid),
        .index (win_idx)
    );

    // Commit priority: ecall > ebreak > interrupt > mret.
    always_comb begin
        exc      = commit_valid && (is_ecall || is_ebreak);
        take_irq = commit_valid && !exc && mstatus_mie && win_valid;
        do_mret  = commit_valid && is_mret && !exc && !take_irq;
        trap     = exc || take_irq;
    end

    // PC redirect toward the trap vector or back to mepc.
    always_comb begin
        redirect_valid = trap || do_mret;
        complete       = do_mret;
        redirect_pc    = '0;
        if (trap) begin
            redirect_pc = tvec_base;
            if (take_irq && (mtvec_q[1:0] == TVEC_VECTORED))
                redirect_pc = tvec_base + vec_off;
        end else if (do_mret) begin
            redirect_pc = mepc_q;
        end
    end

    // CSR state; trap/MRET updates override software writes to mstatus,
    // mepc and mcause, while mie/mtvec writes always land.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q        <= '0;
            mie_q        <= '1;
            mstatus_mie  <= 1'b1;
            mstatus_mpie <= 1'b0;
            mtvec_q      <= TVEC_RESET;
            mepc_q       <= '0;
            mcause_q     <= '0;
        end else begin
            irq_q <= irq;
            if (csr_we) begin
                case (csr_addr)
                    CSR_MIE:   mie_q   <= csr_wdata[NUM_IRQ-1:0];
                    CSR_MTVEC: mtvec_q <= {csr_wdata[XLEN-1:2], tvec_legal(csr_wdata[1:0])};
                    default: ;
                endcase
            end
            if (trap) begin
                mepc_q       <= (exc ? commit_pc : commit_pc_n) & ALIGN_MASK;
                if (exc)
                    mcause_q <= is_ecall ? XLEN'(CAUSE_ECALL_M) : XLEN'(CAUSE_BREAKPOINT);
                else
                    mcause_q <= {1'b1, (XLEN-1)'(win_idx)};
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end else if (do_mret) begin
                mstatus_mie  <= mstatus_mpie;
                mstatus_mpie <= 1'b1;
            end else if (csr_we) begin
                case (csr_addr)
                    CSR_MSTATUS: begin
                        mstatus_mie  <= csr_wdata[MSTATUS_MIE_BIT];
                        mstatus_mpie <= csr_wdata[MSTATUS_MPIE_BIT];
                    end
                    CSR_MEPC:   mepc_q   <= csr_wdata & ALIGN_MASK;
                    CSR_MCAUSE: mcause_q <= csr_wdata;
                    default: ;
                endcase
            end
        end
    end

    // Combinational CSR read; unmapped addresses read zero.
    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            CSR_MSTATUS: begin
                csr_rdata[MSTATUS_MIE_BIT]  = mstatus_mie;
                csr_rdata[MSTATUS_MPIE_BIT] = mstatus_mpie;
            end
            CSR_MIE:    csr_rdata = XLEN'(mie_q);
            CSR_MTVEC:  csr_rdata = mtvec_q;
            CSR_MEPC:   csr_rdata = mepc_q;
            CSR_MCAUSE: csr_rdata = mcause_q;
            CSR_MIP:    csr_rdata = XLEN'(pending);
            default: ;
        endcase
    end

endmodule
